// File: rtl/std_cache_pkg.sv
// Shared cache geometry and line/byte-enable types for the data cache.
package std_cache_pkg;

  localparam int NR_WAYS     = 8;
  localparam int INDEX_WIDTH = 12;
  localparam int TAG_WIDTH   = 44;
  localparam int LINE_WIDTH  = 128;

  // One way's worth of SRAM contents at a given index.
  typedef struct packed {
    logic [TAG_WIDTH-1:0]  tag;
    logic [LINE_WIDTH-1:0] data;
    logic                  valid;
    logic                  dirty;
  } cache_line_t;

  // Per-field write enables matching cache_line_t.
  typedef struct packed {
    logic [(TAG_WIDTH+7)/8-1:0] tag;
    logic [LINE_WIDTH/8-1:0]    data;
    logic                       valid;
    logic                       dirty;
  } cl_be_t;

endpackage

// File: rtl/rr_starve_arb.sv
// Arbiter for the non-miss-handler ports: fixed priority or round-robin,
// with per-port starvation counters that force a long-waiting port to win.
// Local index 0 corresponds to global port 1.
module rr_starve_arb #(
  parameter int NR_PORTS     = 3,
  parameter int STARVE_LIMIT = 8,
  parameter bit ROUND_ROBIN  = 1'b0,
  localparam int PW = (NR_PORTS > 1) ? $clog2(NR_PORTS) : 1,
  localparam int CW = $clog2(STARVE_LIMIT + 1)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [NR_PORTS-1:0] req_i,
  input  logic                block_i,   // higher-priority port owns this cycle
  output logic [NR_PORTS-1:0] gnt_o,
  output logic [PW-1:0]       idx_o
);

  logic [NR_PORTS-1:0][CW-1:0] cnt;
  logic [NR_PORTS-1:0]         starved;
  logic [PW-1:0]               ptr;     // first index searched in RR mode
  logic                        found;

  for (genvar i = 0; i < NR_PORTS; i++) begin : g_starve
    assign starved[i] = req_i[i] && (cnt[i] == CW'(STARVE_LIMIT));
  end

  // Pick a winner: starved ports first (lowest index), then RR or fixed.
  // Loops run high-to-low so the last hit is the highest-priority one.
  always_comb begin
    int j;
    j     = 0;
    found = 1'b0;
    idx_o = '0;
    gnt_o = '0;
    if (|starved) begin
      found = 1'b1;
      for (int i = NR_PORTS - 1; i >= 0; i--)
        if (starved[i]) idx_o = PW'(i);
    end else if (ROUND_ROBIN) begin
      for (int off = NR_PORTS - 1; off >= 0; off--) begin
        j = int'(ptr) + off;
        if (j >= NR_PORTS) j = j - NR_PORTS;
        if (req_i[PW'(j)]) begin
          idx_o = PW'(j);
          found = 1'b1;
        end
      end
    end else begin
      for (int i = NR_PORTS - 1; i >= 0; i--)
        if (req_i[i]) begin
          idx_o = PW'(i);
          found = 1'b1;
        end
    end
    if (found && !block_i) gnt_o[idx_o] = 1'b1;
  end

  // Starvation counters and RR pointer; pointer moves only on our own grants.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt <= '0;
      ptr <= '0;
    end else begin
      for (int i = 0; i < NR_PORTS; i++) begin
        if (!req_i[i] || gnt_o[i])             cnt[i] <= '0;
        else if (cnt[i] != CW'(STARVE_LIMIT))  cnt[i] <= cnt[i] + CW'(1);
      end
      if (|gnt_o)
        ptr <= (idx_o == PW'(NR_PORTS - 1)) ? '0 : idx_o + PW'(1);
    end
  end

endmodule

// File: rtl/dcache_mem_arb.sv
// Data-cache SRAM arbiter: port 0 (miss handler) always wins, the rest go
// through rr_starve_arb. The winner's tag is compared against all ways one
// cycle after the grant.
module dcache_mem_arb import std_cache_pkg::*; #(
  parameter int NR_PORTS     = 4,
  parameter int NR_WAYS      = std_cache_pkg::NR_WAYS,
  parameter int INDEX_WIDTH  = std_cache_pkg::INDEX_WIDTH,
  parameter int TAG_WIDTH    = std_cache_pkg::TAG_WIDTH,
  parameter int LINE_WIDTH   = std_cache_pkg::LINE_WIDTH,
  parameter bit ROUND_ROBIN  = 1'b0,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic [NR_PORTS-1:0][NR_WAYS-1:0]    req_i,
  input  logic [NR_PORTS-1:0][INDEX_WIDTH-1:0] addr_i,
  input  logic [NR_PORTS-1:0][TAG_WIDTH-1:0]  tag_i,
  input  cache_line_t [NR_PORTS-1:0]          wdata_i,
  input  logic [NR_PORTS-1:0]                 we_i,
  input  cl_be_t [NR_PORTS-1:0]               be_i,
  output logic [NR_PORTS-1:0]                 gnt_o,
  output cache_line_t [NR_WAYS-1:0]           rdata_o,
  output logic [NR_WAYS-1:0]                  hit_way_o,
  output logic                                multi_hit_o,
  output logic [NR_WAYS-1:0]                  req_o,
  output logic [INDEX_WIDTH-1:0]              addr_o,
  output cache_line_t                         wdata_o,
  output logic                                we_o,
  output cl_be_t                              be_o,
  input  cache_line_t [NR_WAYS-1:0]           rdata_i
);

  localparam int IW = (NR_PORTS > 1) ? $clog2(NR_PORTS) : 1;
  localparam int M  = NR_PORTS - 1;
  localparam int PW = (M > 1) ? $clog2(M) : 1;

  if (LINE_WIDTH != $bits(rdata_i[0].data)) begin : g_chk
    $error("LINE_WIDTH does not match cache_line_t");
  end

  logic          req0, any, valid_q, we_q;
  logic [M-1:0]  sub_req, sub_gnt;
  logic [PW-1:0] sub_idx;
  logic [IW-1:0] id, id_q;

  // Requests are masked during reset so no grant leaks out combinationally.
  assign req0 = rst_ni & (|req_i[0]);
  for (genvar p = 1; p < NR_PORTS; p++) begin : g_req
    assign sub_req[p-1] = rst_ni & (|req_i[p]);
  end

  rr_starve_arb #(
    .NR_PORTS    (M),
    .STARVE_LIMIT(STARVE_LIMIT),
    .ROUND_ROBIN (ROUND_ROBIN)
  ) u_arb (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .req_i  (sub_req),
    .block_i(req0),
    .gnt_o  (sub_gnt),
    .idx_o  (sub_idx)
  );

  assign gnt_o = {sub_gnt, req0};
  assign any   = req0 | (|sub_gnt);
  assign id    = req0 ? '0 : IW'(sub_idx) + IW'(1);

  // Steer the winner's request onto the SRAM side.
  always_comb begin
    req_o   = any ? req_i[id] : '0;
    addr_o  = addr_i[id];
    wdata_o = wdata_i[id];
    be_o    = be_i[id];
    we_o    = any & we_i[id];
  end

  // Remember who was granted so its tag can be compared next cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      id_q    <= '0;
      valid_q <= 1'b0;
      we_q    <= 1'b0;
    end else begin
      id_q    <= id;
      valid_q <= any;
      we_q    <= we_o;
    end
  end

  // Tag compare per way; writes never report a hit.
  for (genvar w = 0; w < NR_WAYS; w++) begin : g_hit
    assign hit_way_o[w] = valid_q & ~we_q & rdata_i[w].valid &
                          (rdata_i[w].tag == tag_i[id_q]);
  end

  assign multi_hit_o = |(hit_way_o & (hit_way_o - NR_WAYS'(1)));
  assign rdata_o     = rdata_i;

endmodule

// File: tb/tb_dcache_mem_arb.sv
// Directed bench for dcache_mem_arb: a fixed-priority and a round-robin
// instance share the same stimulus.
module tb_dcache_mem_arb;
  import std_cache_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic [3:0][7:0]  req;
  logic [3:0][11:0] addr;
  logic [3:0][43:0] tag;
  cache_line_t [3:0] wdata;
  logic [3:0]       we;
  cl_be_t [3:0]     be;
  cache_line_t [7:0] rdata;

  logic [3:0] gnt_f, gnt_r;
  cache_line_t [7:0] rdo_f, rdo_r;
  logic [7:0] hit_f, hit_r, sreq_f, sreq_r;
  logic mh_f, mh_r, swe_f, swe_r;
  logic [11:0] saddr_f, saddr_r;
  cache_line_t swd_f, swd_r;
  cl_be_t sbe_f, sbe_r;

  logic [3:0] e;
  int n_run = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  dcache_mem_arb #(.ROUND_ROBIN(1'b0)) dut_f (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .addr_i(addr), .tag_i(tag),
    .wdata_i(wdata), .we_i(we), .be_i(be), .gnt_o(gnt_f), .rdata_o(rdo_f),
    .hit_way_o(hit_f), .multi_hit_o(mh_f), .req_o(sreq_f), .addr_o(saddr_f),
    .wdata_o(swd_f), .we_o(swe_f), .be_o(sbe_f), .rdata_i(rdata));

  dcache_mem_arb #(.ROUND_ROBIN(1'b1)) dut_r (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .addr_i(addr), .tag_i(tag),
    .wdata_i(wdata), .we_i(we), .be_i(be), .gnt_o(gnt_r), .rdata_o(rdo_r),
    .hit_way_o(hit_r), .multi_hit_o(mh_r), .req_o(sreq_r), .addr_o(saddr_r),
    .wdata_o(swd_r), .we_o(swe_r), .be_o(sbe_r), .rdata_i(rdata));

  task automatic chk(input string t, input logic [63:0] obs, input logic [63:0] exp);
    n_run++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", t, obs, exp);
    end
  endtask

  function automatic cache_line_t mkl(input logic [43:0] t, input logic v);
    cache_line_t l;
    l = '0;
    l.tag = t;
    l.valid = v;
    return l;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req = '0; we = '0; rdata = '0;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    req = '0; addr = '0; tag = '0; wdata = '0; we = '0; be = '0; rdata = '0;
    rst_n = 1'b0;

    // outputs held quiet under reset even with live requests and matching data
    req[0] = 8'h01; req[2] = 8'h04; tag[0] = 44'h1234; rdata[0] = mkl(44'h1234, 1'b1);
    step(); step(); settle();
    chk("rst_gnt_f", gnt_f, 4'b0000);
    chk("rst_gnt_r", gnt_r, 4'b0000);
    chk("rst_sreq", sreq_f, 8'h00);
    chk("rst_hit", hit_f, 8'h00);
    chk("rst_mh", mh_f, 1'b0);

    // port 0 and port 2 together: port 0 first, then port 2
    step(); rst_n = 1'b1; rdata = '0; addr[0] = 12'h111; addr[2] = 12'h222;
    settle();
    chk("p0_win_f", gnt_f, 4'b0001);
    chk("p0_win_r", gnt_r, 4'b0001);
    chk("p0_sreq", sreq_f, 8'h01);
    chk("p0_addr", saddr_f, 12'h111);
    step(); req[0] = 8'h00;
    settle();
    chk("p2_next", gnt_f, 4'b0100);
    chk("p2_addr", saddr_f, 12'h222);
    chk("p2_sreq", sreq_f, 8'h04);

    // round-robin over 1,2,3; fixed instance keeps granting port 1
    step(); do_reset();
    req[1] = 8'h01; req[2] = 8'h01; req[3] = 8'h01;
    for (int c = 0; c < 6; c++) begin
      e = 4'b0010 << (c % 3);
      settle();
      chk($sformatf("rr_order_%0d", c), gnt_r, e);
      chk($sformatf("fix_order_%0d", c), gnt_f, 4'b0010);
      step();
    end

    // starvation: port 3 forced in on cycle 9, and again on 19 after port 0
    do_reset();
    req[1] = 8'h01; req[3] = 8'h01;
    for (int c = 1; c <= 19; c++) begin
      req[0] = (c == 18) ? 8'h01 : 8'h00;
      e = (c == 9 || c == 19) ? 4'b1000 : (c == 18) ? 4'b0001 : 4'b0010;
      settle();
      chk($sformatf("starve_c%0d", c), gnt_f, e);
      step();
    end

    // single-way hit
    do_reset();
    req[1] = 8'h04; tag[1] = 44'h1234; rdata[2] = mkl(44'h1234, 1'b1);
    settle();
    chk("hit_gnt", gnt_f, 4'b0010);
    chk("hit_pre", hit_f, 8'h00);
    step(); req[1] = 8'h00;
    settle();
    chk("hit_w2", hit_f, 8'h04);
    chk("mh_w2", mh_f, 1'b0);
    chk("rdata_pass", rdo_f[2].tag, 44'h1234);
    step();
    settle();
    chk("hit_idle", hit_f, 8'h00);

    // multi-hit on ways 1 and 5; mismatching and invalid ways excluded
    step(); req[2] = 8'h22; tag[2] = 44'hABC; tag[0] = 44'hABD; rdata = '0;
    settle();
    chk("mh_gnt", gnt_f, 4'b0100);
    step(); req[2] = 8'h00;
    rdata[1] = mkl(44'hABC, 1'b1); rdata[5] = mkl(44'hABC, 1'b1);
    rdata[3] = mkl(44'hABD, 1'b1); rdata[0] = mkl(44'hABC, 1'b0);
    settle();
    chk("mh_hit", hit_f, 8'h22);
    chk("mh_flag", mh_f, 1'b1);

    // write access reports no hit
    step(); rdata = '0; req[3] = 8'h08; we[3] = 1'b1; tag[3] = 44'h55;
    settle();
    chk("wr_we_o", swe_f, 1'b1);
    step(); req[3] = 8'h00; we[3] = 1'b0; rdata[3] = mkl(44'h55, 1'b1);
    settle();
    chk("wr_nohit", hit_f, 8'h00);

    // back-to-back grants to different ports, compare follows id_q
    step(); rdata = '0; req[1] = 8'h10; tag[1] = 44'h111; tag[2] = 44'h222;
    settle();
    chk("b2b_g1", gnt_f, 4'b0010);
    step(); req[1] = 8'h00; req[2] = 8'h40;
    rdata[4] = mkl(44'h111, 1'b1); rdata[6] = mkl(44'h222, 1'b1);
    settle();
    chk("b2b_g2", gnt_f, 4'b0100);
    chk("b2b_hit1", hit_f, 8'h10);
    step(); req[2] = 8'h00;
    settle();
    chk("b2b_hit2", hit_f, 8'h40);

    // reset right after a grant: compare dropped, RR pointer back to port 1
    step(); do_reset();
    req[1] = 8'h01; req[2] = 8'h01; req[3] = 8'h01;
    tag[1] = 44'h77; rdata[0] = mkl(44'h77, 1'b1);
    settle();
    chk("mid_gnt", gnt_r, 4'b0010);
    step(); rst_n = 1'b0;
    settle();
    chk("mid_rst_hit", hit_r, 8'h00);
    chk("mid_rst_gnt", gnt_r, 4'b0000);
    step(); rst_n = 1'b1;
    settle();
    chk("post_rst_hit", hit_r, 8'h00);
    chk("post_rst_ptr", gnt_r, 4'b0010);
    step();
    settle();
    chk("post_rst_gnt2", gnt_r, 4'b0100);
    chk("post_rst_hit2", hit_r, 8'h01);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
